// File: rtl/display_scanout.sv
`default_nettype none
// ============================================================================
// display_scanout : VGA-style raster timing generator and pixel pipeline
// Revision: 1.0
// ============================================================================
module display_scanout #(
  parameter int   BPP     = 4,
  parameter int   HACTIVE = 640,
  parameter int   HFP     = 16,
  parameter int   HSYNC   = 96,
  parameter int   HBP     = 48,
  parameter int   VACTIVE = 480,
  parameter int   VFP     = 10,
  parameter int   VSYNC   = 2,
  parameter int   VBP     = 33,
  parameter logic HPOL    = 1'b0,
  parameter logic VPOL    = 1'b0,
  parameter int   RDLAT   = 1,
  parameter int   AW      = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [3*BPP-1:0] solid_rgb,
  output logic [AW-1:0]    fb_addr,
  output logic             fb_re,
  input  logic [3*BPP-1:0] fb_data,
  output logic [BPP-1:0]   red,
  output logic [BPP-1:0]   grn,
  output logic [BPP-1:0]   blu,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame
);

  localparam int HT   = HACTIVE + HFP + HSYNC + HBP;
  localparam int VT   = VACTIVE + VFP + VSYNC + VBP;
  localparam int HW   = $clog2(HT);
  localparam int VW   = $clog2(VT);
  localparam int BARW = HACTIVE / 8;
  localparam int BW   = $clog2(BARW + 1);
  localparam int CW   = 3 * BPP;

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic [31:0]   hcx, vcx;
  logic [AW-1:0] addr_q;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar;
  logic [1:0]    mode_q;
  logic          hwrap, vwrap, act0, hs0, vs0, frm0, grid0;

  assign hcx   = 32'(hc);
  assign vcx   = 32'(vc);
  assign hwrap = (hc == HW'(HT - 1));
  assign vwrap = (vc == VW'(VT - 1));
  assign act0  = (hcx < HACTIVE) && (vcx < VACTIVE);
  assign hs0   = (hcx >= HACTIVE + HFP) && (hcx < HACTIVE + HFP + HSYNC);
  assign vs0   = (vcx >= VACTIVE + VFP) && (vcx < VACTIVE + VFP + VSYNC);
  assign frm0  = (hc == '0) && (vc == '0);
  assign grid0 = (hc[3:0] == 4'd0) || (vc[3:0] == 4'd0);

  assign fb_addr = addr_q;
  assign fb_re   = act0 && !reset;

  // Stage 0: raster counters, linear fetch address and the divide-free bar counter
  always_ff @(posedge clk) begin
    if (reset) begin
      hc     <= '0;
      vc     <= '0;
      addr_q <= '0;
      bar_px <= '0;
      bar    <= '0;
      mode_q <= 2'd0;
    end else begin
      hc <= hwrap ? '0 : hc + HW'(1);
      if (hwrap) vc <= vwrap ? '0 : vc + VW'(1);
      if (hwrap && vwrap)  addr_q <= '0;
      else if (act0)       addr_q <= addr_q + AW'(1);
      if (frm0) mode_q <= mode;
      if (hwrap) begin
        bar_px <= '0;
        bar    <= '0;
      end else if (act0) begin
        if (bar_px == BW'(BARW - 1)) begin
          bar_px <= '0;
          bar    <= bar + 3'd1;
        end else begin
          bar_px <= bar_px + BW'(1);
        end
      end
    end
  end

  // Control delay line matching the framebuffer read latency
  logic [7:0] pipe [RDLAT];
  logic [7:0] st0;
  assign st0 = {act0, hs0, vs0, frm0, grid0, bar};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RDLAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= st0;
      for (int i = 1; i < RDLAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic          d_act, d_hs, d_vs, d_frm, d_grid;
  logic [2:0]    d_bar;
  logic [CW-1:0] pix;
  assign {d_act, d_hs, d_vs, d_frm, d_grid, d_bar} = pipe[RDLAT-1];

  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0:    pix = fb_data;
      2'd1:    pix = {{BPP{~d_bar[1]}}, {BPP{~d_bar[2]}}, {BPP{~d_bar[0]}}};
      2'd2:    pix = solid_rgb;
      default: pix = {CW{d_grid}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red    <= '0;
      grn    <= '0;
      blu    <= '0;
      hsync  <= ~HPOL;
      vsync  <= ~VPOL;
      active <= 1'b0;
      frame  <= 1'b0;
    end else begin
      {red, grn, blu} <= d_act ? pix : '0;
      hsync  <= d_hs ? HPOL : ~HPOL;
      vsync  <= d_vs ? VPOL : ~VPOL;
      active <= d_act;
      frame  <= d_frm;
    end
  end

endmodule
`default_nettype wire
